pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline register for all inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined LEGv8 CPU.
- Replaces the fixed, always-advancing stage latches with a valid/ready stage that has a 2-entry skid buffer, synchronous flush, and saturating stall/flush counters.
- Enables load-use stalls and branch squashes without a combinational ready path through the stage.

Parameters:
- DATA_W, 96, payload width in bits (default = 64-bit PC + 32-bit instruction for IF/ID).
- COUNT_W, 32, width of the stall and flush performance counters.
- BUBBLE, 0 (DATA_W bits), payload value driven on out_data at reset and after flush (0 decodes as no-op/no-write in control_unit).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream stage presents a valid payload
- in_ready  out  1  stage can accept a payload this cycle; registered output
- in_data  in  DATA_W  upstream payload
- flush  in  1  synchronous squash of all held entries (branch taken / jump)
- out_valid  out  1  out_data holds a valid payload
- out_ready  in  1  downstream stage accepts; held low by the hazard unit to stall
- out_data  out  DATA_W  payload to the downstream stage; registered
- occupancy  out  2  number of held entries, 0..2
- stall_count  out  COUNT_W  cycles with out_valid=1 and out_ready=0; saturating
- flush_count  out  COUNT_W  cycles with flush=1 and occupancy>0; saturating

Behaviour:
- Reset (reset_n=0, asynchronous):
  - occupancy=0, out_valid=0, in_ready=1, out_data=BUBBLE, both counters=0.
  - Reset asserted mid-transfer discards both entries with no partial update.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_data is sampled only on in_fire.
  - out_data/out_valid are stable while out_valid=1 & out_ready=0.
- Latency: 1 cycle from in_fire to out_valid when occupancy is 0.
- State = occupancy, with entries MAIN (drives out_data) and SKID.
  - EMPTY(0): in_fire -> ONE, MAIN<=in_data.
  - ONE(1):
    - in_fire & out_fire -> ONE, MAIN<=in_data.
    - in_fire & !out_fire -> FULL, SKID<=in_data.
    - !in_fire & out_fire -> EMPTY.
    - neither -> hold.
  - FULL(2): in_ready=0, so no input is taken. out_fire -> ONE, MAIN<=SKID.
- in_ready is registered:
  - Next value = 1 unless the next state is FULL.
  - Never depends combinationally on out_ready.
- Flush (highest priority after reset):
  - Next state is EMPTY, out_data<=BUBBLE, in_ready<=1.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still completes (downstream consumed it).
- out_valid=0 implies out_data=BUBBLE. EMPTY always drives BUBBLE so downstream control decodes a no-op.
- Counters:
  - Each increments by 1 per qualifying cycle.
  - Each saturates at 2^COUNT_W-1 with no wrap.
  - Both are cleared only by reset.
- stall_count and flush_count may increment in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - stage payload widths (IF_ID_W=96, ID_EX_W, EX_MEM_W, MEM_WB_W);
  - BUBBLE constants per stage;
  - COUNT_W default.
- One sub-module: sat_counter (COUNT_W, inc enable, saturating), instantiated twice.

Test Plan:
- Reset and pass-through:
  - Hold reset_n=0 for 2 cycles, then release. Expect in_ready=1, out_valid=0, out_data=0.
  - Drive in_data=0x...0004_D2800020 with out_ready=1. Expect out_data equal to it one cycle later, occupancy=1.
- Back-to-back streaming: 8 consecutive payloads 1..8 with in_valid=1, out_ready=1. Expect outputs 1..8 in order, one per cycle, occupancy never 2, stall_count=0.
- Stall into skid:
  - Hold out_ready=0 while sending payloads A, B. Expect occupancy=2, in_ready=0, out_data=A held.
  - Hold the stall 3 cycles. Expect stall_count=3.
  - Release out_ready. Expect A, then B, with in_ready=1 the cycle after A leaves.
- Flush with simultaneous input: from FULL, assert flush with in_valid=1, in_data=C. Expect next cycle occupancy=0, out_valid=0, out_data=BUBBLE, flush_count=1, and C never appears.
- Flush when empty: assert flush at occupancy 0. Expect flush_count unchanged and the state stays EMPTY.
- Counter saturation with COUNT_W=3: stall for 10 cycles. Expect stall_count to reach 7 and hold at 7. Assert reset mid-stall and expect all outputs to return to reset values asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipelined LEGv8 CPU stage boundaries.
//   - Payload widths of each inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   - Bubble (no-op) payload per stage; all-zero decodes as no-op/no-write
//   - Default width of the stage performance counters
//   - Occupancy encoding of a pipeline stage register
// -----------------------------------------------------------------------------
package cpu_pkg;

  // PC (64) + instruction (32)
  localparam int IF_ID_W  = 96;
  // PC, read data 1/2, sign-extended immediate (4 x 64), rd (5), opcode (11), control (10)
  localparam int ID_EX_W  = 282;
  // branch target, ALU result, store data (3 x 64), rd (5), zero flag (1), control (6)
  localparam int EX_MEM_W = 204;
  // load data, ALU result (2 x 64), rd (5), control (2)
  localparam int MEM_WB_W = 135;

  localparam int COUNT_W_DEF = 32;

  localparam logic [IF_ID_W-1:0]  IF_ID_BUBBLE  = '0;
  localparam logic [ID_EX_W-1:0]  ID_EX_BUBBLE  = '0;
  localparam logic [EX_MEM_W-1:0] EX_MEM_BUBBLE = '0;
  localparam logic [MEM_WB_W-1:0] MEM_WB_BUBBLE = '0;

  // Number of payloads held by a stage register.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Free-running event counter that increments by one on each cycle with inc=1
// and sticks at its all-ones value instead of wrapping. Cleared only by reset.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   inc      in   count this cycle
//   count    out  COUNT_W  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline register used at every inter-stage boundary of the
// LEGv8 pipeline. Holds up to two payloads (MAIN drives out_data, SKID catches
// the payload that was already in flight when downstream stalled), so in_ready
// can be a plain flop with no combinational path from out_ready. A synchronous
// flush squashes everything held and forces the bubble payload onto out_data.
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   in_valid     in   upstream payload valid
//   in_ready     out  stage accepts a payload this cycle (registered)
//   in_data      in   DATA_W upstream payload
//   flush        in   squash all held entries (branch taken / jump)
//   out_valid    out  out_data holds a valid payload
//   out_ready    in   downstream accepts; held low to stall
//   out_data     out  DATA_W payload to downstream (registered, BUBBLE when empty)
//   occupancy    out  2  number of held entries, 0..2
//   stall_count  out  COUNT_W  cycles with out_valid=1 and out_ready=0 (saturating)
//   flush_count  out  COUNT_W  cycles with flush=1 and occupancy>0 (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int                DATA_W  = IF_ID_W,
  parameter int                COUNT_W = COUNT_W_DEF,
  parameter logic [DATA_W-1:0] BUBBLE  = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;

  logic              held;
  logic              in_fire;
  logic              out_fire;
  logic              stall_inc;
  logic              flush_inc;

  assign held      = (occ_q != OCC_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = held & out_ready;
  assign stall_inc = held & ~out_ready;
  assign flush_inc = flush & held;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q      <= OCC_EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      occ_q      <= occ_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      // A same-cycle out_fire has already been consumed downstream; a
      // same-cycle in_fire is dropped along with everything held.
      occ_d  = OCC_EMPTY;
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            occ_d  = OCC_ONE;
            main_d = in_data;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            occ_d  = OCC_FULL;
            skid_d = in_data;
          end else if (out_fire) begin
            // Empty stage must present a no-op to downstream decode.
            occ_d  = OCC_EMPTY;
            main_d = BUBBLE;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            occ_d  = OCC_ONE;
            main_d = skid_q;
            skid_d = BUBBLE;
          end
        end
        default: begin
          occ_d  = OCC_EMPTY;
          main_d = BUBBLE;
          skid_d = BUBBLE;
        end
      endcase
    end
    // Decided from the next state only, so out_ready never reaches in_ready
    // combinationally.
    in_ready_d = (occ_d != OCC_FULL);
  end

  // Output logic
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = held;
    out_data  = main_q;
    occupancy = occ_q;
  end

  sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .count   (stall_count)
  );

  sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .count   (flush_count)
  );

endmodule
